jtframe_mister_shell: RTL and testbench
=======================================

Name: jtframe_mister_shell

Overview:
- Control shell between the MiSTer HPS interface and the game core. Supervises PLL lock and generates system and game resets.
- Decodes OSD status bits into DIP-style controls and maps HPS joystick words to active-low game inputs.
- Converts the HPS byte-wide ROM download into a 16-bit-word programming interface for the SDRAM loader.
- Sits between the hps_io/pll instances and the game top; the SDRAM controller and scandoubler are outside this block.

Parameters:
- THREE_BUTTONS, 1: 0 forces button 3 (joystick bit 6) inactive on both players.
- RST_CYCLES, 255: reset hold length in clk_sys cycles after the last reset cause clears; range 1..65535.

Ports:
- clk_sys in 1: sole clock.
- RESET in 1: asynchronous, active-high reset.
- pll_locked in 1: PLL lock indicator, synchronised internally with 2 flops.
- pll_rst out 1: PLL reset request.
- status in 32: OSD status word.
- buttons in 2: board buttons; bit1 requests reset.
- joystick_0, joystick_1 in 16: HPS joystick words, active-high.
- ioctl_download in 1: ROM download active.
- ioctl_wr in 1: byte strobe.
- ioctl_addr in 22: byte address.
- ioctl_data in 8: byte data.
- rst, rst_n out 1: system reset and its complement.
- game_rst, game_rst_n out 1: game reset and its complement.
- downloading, dwnld_busy out 1: registered download flag.
- prog_addr out 22; prog_data out 8; prog_mask out 2; prog_we out 1; prog_rd out 1.
- game_joystick1, game_joystick2 out 10: active-low.
- game_coin, game_start out 2: active-low.
- game_service out 1: active-low.
- enable_fm, enable_psg, dip_test, dip_pause, dip_flip, rotate out 1.
- dip_fxlevel out 2.
- gfx_en out 4.
- LED out 1.

Behaviour:
- All registers reset asynchronously on RESET; every output below is registered unless stated.
- PLL supervisor:
  - On RESET: pll_rst=0, cnt=0xD0, last_locked=0.
  - Each cycle: last_locked<=lock_sync.
  - On a 1→0 lock edge: cnt<=0xFF and pll_rst<=1.
  - Otherwise cnt decrements while nonzero; pll_rst clears when cnt==0.
  - A lock loss during the countdown reloads cnt to 0xFF.
- System reset:
  - Cause = !lock_sync | status[0] | buttons[1].
  - While a cause is present, the hold counter loads RST_CYCLES and rst=1.
  - After all causes clear, rst stays 1 until the counter reaches 0; rst falls exactly RST_CYCLES cycles after the causes clear.
  - Reset values: rst=1, rst_n=0.
- Game reset:
  - game_rst has the same structure as rst, with causes rst | downloading and its own counter.
  - Reset values: game_rst=1, game_rst_n=0.
- Download path:
  - downloading <= ioctl_download; dwnld_busy = downloading.
  - On ioctl_wr while ioctl_download, next cycle: prog_we=1 for exactly one cycle.
  - Same cycle: prog_addr={1'b0,ioctl_addr[21:1]}, prog_data=ioctl_data.
  - prog_mask is active-low byte select: 2'b10 when addr[0]=0, 2'b01 when addr[0]=1.
  - ioctl_wr with ioctl_download=0 is ignored. prog_rd is tied 0.
  - Reset values: prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0.
- Joysticks:
  - game_joystickN = ~joystick_(N-1)[9:0]; bits 0-3 are right/left/down/up, bits 4-9 are buttons 1-6.
  - When THREE_BUTTONS=0, bit 6 is forced 1.
  - game_start[N-1] = ~joystick_(N-1)[10]; game_coin[N-1] = ~joystick_(N-1)[11].
  - game_service = ~joystick_0[13].
  - Reset values: joystick, coin, start and service outputs all 1s.
- Pause:
  - A rising edge of joystick_0[12] or joystick_1[12] toggles the internal pause flag; dip_pause = ~pause.
  - Pause is cleared while downloading or rst.
  - Reset: dip_pause=1.
- DIP decode (reset values are the decode of status=0):
  - dip_test = ~status[6].
  - enable_psg = ~status[7].
  - enable_fm = ~status[8].
  - dip_fxlevel = status[11:10]^2'b10.
  - dip_flip = status[12].
  - rotate = ~status[13].
- gfx_en = 4'hF.
- LED = downloading | pause.

Optional Feature:
- JTFRAME_LOCKRST_EN defined: PLL supervisor is instantiated as above.
- Not defined: pll_rst is tied 0 and no supervisor logic exists; the lock input still feeds rst.

Test Plan:
- Release RESET with pll_locked=1 held → rst, game_rst fall exactly 255 cycles later; pll_rst stays 0 throughout.
- After a clean lock, drop pll_locked for one cycle (JTFRAME_LOCKRST_EN) → pll_rst=1 for 256 cycles; rst re-asserts and later releases 255 cycles after lock returns.
- ioctl_download=1, write 0xAB at address 0x000005 → next cycle prog_we=1, prog_addr=0x000002, prog_data=0xAB, prog_mask=2'b01; game_rst stays 1 until 255 cycles after download ends.
- joystick_0=0x0C10 → game_joystick1=10'h3EF, game_coin=2'b10, game_start=2'b10; with THREE_BUTTONS=0 and bit6 set → game_joystick1[6]=1.
- status=0x00000C80 → enable_psg=0, enable_fm=1, dip_fxlevel=2'b01, rotate=1, dip_flip=0; status[0]=1 → rst=1.
- Two rising edges on joystick_0[12] → dip_pause 1→0→1, LED follows; raising ioctl_download while paused → dip_pause=1.

Source files
------------

// File: rtl/jtframe_mister_shell_if.sv
// jtframe_mister_shell_if
// ROM download bus between the HPS (hps_io) and the game-side SDRAM loader.
//   ioctl_download : HPS is streaming a ROM image
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address of the strobed byte
//   ioctl_data     : strobed byte
//   prog_addr      : 16-bit word address for the loader
//   prog_data      : byte to program
//   prog_mask      : active-low byte lane select (bit0 = low byte)
//   prog_we        : one-cycle program strobe
//   prog_rd        : loader read request (unused, always 0)
// master = HPS side, slave = the shell that converts bytes into word writes.
interface jtframe_mister_shell_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rd;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        input  prog_addr, prog_data, prog_mask, prog_we, prog_rd
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        output prog_addr, prog_data, prog_mask, prog_we, prog_rd
    );
endinterface

// File: rtl/jtframe_mister_shell.sv
// jtframe_mister_shell
// Control shell between the MiSTer HPS interface and the game core.
// Supervises PLL lock, stretches system/game resets, decodes OSD status
// bits into DIP-style controls, maps HPS joystick words to active-low game
// inputs and turns the byte-wide ROM download into 16-bit word writes.
//
// Ports:
//   clk_sys, RESET        : sole clock, async active-high reset
//   pll_locked / pll_rst  : PLL lock input (2-flop synchronised) / reset request
//   status, buttons       : OSD status word, board buttons (bit1 = reset)
//   joystick_0/1          : HPS joystick words, active-high
//   bus                   : ROM download bus (slave side)
//   rst/rst_n, game_rst/game_rst_n : stretched resets
//   downloading, dwnld_busy: registered download flag
//   game_joystick1/2, game_coin, game_start, game_service : active-low inputs
//   enable_fm, enable_psg, dip_test, dip_pause, dip_flip, rotate,
//   dip_fxlevel, gfx_en, LED : decoded controls
//
// Build option: define JTFRAME_LOCKRST_EN to include the PLL lock-loss
// supervisor; without it pll_rst is tied low.
//
// The lock synchroniser starts at 0, so after RESET the system reset
// counter only begins once the synchronised lock arrives two cycles later.
module jtframe_mister_shell #(
    parameter int THREE_BUTTONS = 1,
    parameter int RST_CYCLES    = 255
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        pll_locked,
    output logic        pll_rst,
    input  logic [31:0] status,
    input  logic [1:0]  buttons,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    jtframe_mister_shell_if.slave bus,
    output logic        rst,
    output logic        rst_n,
    output logic        game_rst,
    output logic        game_rst_n,
    output logic        downloading,
    output logic        dwnld_busy,
    output logic [9:0]  game_joystick1,
    output logic [9:0]  game_joystick2,
    output logic [1:0]  game_coin,
    output logic [1:0]  game_start,
    output logic        game_service,
    output logic        enable_fm,
    output logic        enable_psg,
    output logic        dip_test,
    output logic        dip_pause,
    output logic        dip_flip,
    output logic        rotate,
    output logic [1:0]  dip_fxlevel,
    output logic [3:0]  gfx_en,
    output logic        LED
);
    localparam logic [15:0] RST_LOAD  = 16'(RST_CYCLES);
    localparam logic [9:0]  BTN3_KILL = (THREE_BUTTONS == 0) ? 10'h040 : 10'h000;

    logic lockMeta_q, lockSync_q;
    logic [15:0] rstCnt_q, rstCnt_d, gameCnt_q, gameCnt_d;
    logic rst_q, rst_d, gameRst_q, gameRst_d;
    logic downloading_q, pause_q, pause_d;
    logic [1:0] pauseBtn_q;
    logic progWe_q, progWe_d;
    logic [21:0] progAddr_q;
    logic [7:0] progData_q;
    logic [1:0] progMask_q;
    logic [9:0] joy1_q, joy2_q;
    logic [1:0] coin_q, start_q, fxLevel_q;
    logic service_q, dipTest_q, enPsg_q, enFm_q, dipFlip_q, rotate_q;
    logic rstCause, gameCause, pauseRise;

    // Two-flop synchroniser for the asynchronous PLL lock signal
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            lockMeta_q <= 1'b0;
            lockSync_q <= 1'b0;
        end else begin
            lockMeta_q <= pll_locked;
            lockSync_q <= lockMeta_q;
        end
    end

`ifdef JTFRAME_LOCKRST_EN
    logic [7:0] pllCnt_q, pllCnt_d;
    logic pllRst_q, pllRst_d, lastLocked_q;

    // A lock loss (re)arms a 256-cycle PLL reset pulse
    always_comb begin
        pllCnt_d = pllCnt_q;
        pllRst_d = pllRst_q;
        if (lastLocked_q && !lockSync_q) begin
            pllCnt_d = 8'hFF;
            pllRst_d = 1'b1;
        end else begin
            if (pllCnt_q != 8'd0) pllCnt_d = pllCnt_q - 8'd1;
            if (pllCnt_q == 8'd0) pllRst_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            pllCnt_q     <= 8'hD0;
            pllRst_q     <= 1'b0;
            lastLocked_q <= 1'b0;
        end else begin
            pllCnt_q     <= pllCnt_d;
            pllRst_q     <= pllRst_d;
            lastLocked_q <= lockSync_q;
        end
    end

    assign pll_rst = pllRst_q;
`else
    assign pll_rst = 1'b0;
`endif

    // Reset stretchers: a cause reloads the counter, the reset drops once the
    // counter has run down to zero after all causes are gone
    assign rstCause  = ~lockSync_q | status[0] | buttons[1];
    assign gameCause = rst_q | downloading_q;

    always_comb begin
        rstCnt_d  = rstCause  ? RST_LOAD : ((rstCnt_q  != 16'd0) ? rstCnt_q  - 16'd1 : 16'd0);
        gameCnt_d = gameCause ? RST_LOAD : ((gameCnt_q != 16'd0) ? gameCnt_q - 16'd1 : 16'd0);
        rst_d     = (rstCnt_d  != 16'd0);
        gameRst_d = (gameCnt_d != 16'd0);
    end

    // Pause toggles on a press of either player's pause button and is
    // forced off while a ROM loads or the system is in reset
    assign pauseRise = (joystick_0[12] & ~pauseBtn_q[0]) | (joystick_1[12] & ~pauseBtn_q[1]);

    always_comb begin
        pause_d = pause_q;
        if (downloading_q || rst_q) pause_d = 1'b0;
        else if (pauseRise)         pause_d = ~pause_q;
    end

    assign progWe_d = bus.ioctl_download & bus.ioctl_wr;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            rstCnt_q      <= RST_LOAD;
            gameCnt_q     <= RST_LOAD;
            rst_q         <= 1'b1;
            gameRst_q     <= 1'b1;
            downloading_q <= 1'b0;
            pause_q       <= 1'b0;
            pauseBtn_q    <= 2'b00;
            progWe_q      <= 1'b0;
            progAddr_q    <= 22'd0;
            progData_q    <= 8'd0;
            progMask_q    <= 2'b11;
        end else begin
            rstCnt_q      <= rstCnt_d;
            gameCnt_q     <= gameCnt_d;
            rst_q         <= rst_d;
            gameRst_q     <= gameRst_d;
            downloading_q <= bus.ioctl_download;
            pause_q       <= pause_d;
            pauseBtn_q    <= {joystick_1[12], joystick_0[12]};
            progWe_q      <= progWe_d;
            if (progWe_d) begin
                progAddr_q <= {1'b0, bus.ioctl_addr[21:1]};
                progData_q <= bus.ioctl_data;
                progMask_q <= bus.ioctl_addr[0] ? 2'b01 : 2'b10;
            end
        end
    end

    // Input mapping and DIP decode; reset values match an idle joystick and
    // an all-zero status word
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            joy1_q    <= 10'h3FF;
            joy2_q    <= 10'h3FF;
            coin_q    <= 2'b11;
            start_q   <= 2'b11;
            service_q <= 1'b1;
            dipTest_q <= 1'b1;
            enPsg_q   <= 1'b1;
            enFm_q    <= 1'b1;
            fxLevel_q <= 2'b10;
            dipFlip_q <= 1'b0;
            rotate_q  <= 1'b1;
        end else begin
            joy1_q    <= ~joystick_0[9:0] | BTN3_KILL;
            joy2_q    <= ~joystick_1[9:0] | BTN3_KILL;
            coin_q    <= ~{joystick_1[11], joystick_0[11]};
            start_q   <= ~{joystick_1[10], joystick_0[10]};
            service_q <= ~joystick_0[13];
            dipTest_q <= ~status[6];
            enPsg_q   <= ~status[7];
            enFm_q    <= ~status[8];
            fxLevel_q <= status[11:10] ^ 2'b10;
            dipFlip_q <= status[12];
            rotate_q  <= ~status[13];
        end
    end

    logic unused;
    assign unused = ^{status[31:14], status[9], status[5:1], buttons[0],
                      joystick_0[15:14], joystick_1[15:13]};

    assign rst            = rst_q;
    assign rst_n          = ~rst_q;
    assign game_rst       = gameRst_q;
    assign game_rst_n     = ~gameRst_q;
    assign downloading    = downloading_q;
    assign dwnld_busy     = downloading_q;
    assign bus.prog_addr  = progAddr_q;
    assign bus.prog_data  = progData_q;
    assign bus.prog_mask  = progMask_q;
    assign bus.prog_we    = progWe_q;
    assign bus.prog_rd    = 1'b0;
    assign game_joystick1 = joy1_q;
    assign game_joystick2 = joy2_q;
    assign game_coin      = coin_q;
    assign game_start     = start_q;
    assign game_service   = service_q;
    assign dip_test       = dipTest_q;
    assign enable_psg     = enPsg_q;
    assign enable_fm      = enFm_q;
    assign dip_fxlevel    = fxLevel_q;
    assign dip_flip       = dipFlip_q;
    assign rotate         = rotate_q;
    assign dip_pause      = ~pause_q;
    assign gfx_en         = 4'hF;
    assign LED            = downloading_q | pause_q;
endmodule

// File: tb/tb_jtframe_mister_shell.sv
// tb_jtframe_mister_shell
// Bench for jtframe_mister_shell: default instance plus a THREE_BUTTONS=0
// instance sharing the joystick inputs. Download writes are predicted into
// a queue and matched against each prog_we pulse.
module tb_jtframe_mister_shell;
    logic clk_sys = 1'b0;
    logic RESET, pll_locked;
    logic [31:0] status;
    logic [1:0] buttons;
    logic [15:0] joystick_0, joystick_1;

    logic pll_rst, rst, rst_n, game_rst, game_rst_n, downloading, dwnld_busy;
    logic [9:0] game_joystick1, game_joystick2;
    logic [1:0] game_coin, game_start, dip_fxlevel;
    logic game_service, enable_fm, enable_psg, dip_test, dip_pause, dip_flip, rotate, LED;
    logic [3:0] gfx_en;

    logic pllRstB, rstB, rstNB, gameRstB, gameRstNB, dlB, busyB;
    logic [9:0] joy1B, joy2B;
    logic [1:0] coinB, startB, fxB;
    logic serviceB, fmB, psgB, testB, pauseB, flipB, rotateB, ledB;
    logic [3:0] gfxB;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } progTxn;
    progTxn expQ[$];

    jtframe_mister_shell_if bus ();
    jtframe_mister_shell_if busB ();

    always #5 clk_sys = ~clk_sys;

    jtframe_mister_shell dut (
        .clk_sys(clk_sys), .RESET(RESET), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .status(status), .buttons(buttons), .joystick_0(joystick_0), .joystick_1(joystick_1),
        .bus(bus), .rst(rst), .rst_n(rst_n), .game_rst(game_rst), .game_rst_n(game_rst_n),
        .downloading(downloading), .dwnld_busy(dwnld_busy),
        .game_joystick1(game_joystick1), .game_joystick2(game_joystick2),
        .game_coin(game_coin), .game_start(game_start), .game_service(game_service),
        .enable_fm(enable_fm), .enable_psg(enable_psg), .dip_test(dip_test),
        .dip_pause(dip_pause), .dip_flip(dip_flip), .rotate(rotate),
        .dip_fxlevel(dip_fxlevel), .gfx_en(gfx_en), .LED(LED)
    );

    jtframe_mister_shell #(.THREE_BUTTONS(0)) dutB (
        .clk_sys(clk_sys), .RESET(RESET), .pll_locked(pll_locked), .pll_rst(pllRstB),
        .status(status), .buttons(buttons), .joystick_0(joystick_0), .joystick_1(joystick_1),
        .bus(busB), .rst(rstB), .rst_n(rstNB), .game_rst(gameRstB), .game_rst_n(gameRstNB),
        .downloading(dlB), .dwnld_busy(busyB),
        .game_joystick1(joy1B), .game_joystick2(joy2B),
        .game_coin(coinB), .game_start(startB), .game_service(serviceB),
        .enable_fm(fmB), .enable_psg(psgB), .dip_test(testB),
        .dip_pause(pauseB), .dip_flip(flipB), .rotate(rotateB),
        .dip_fxlevel(fxB), .gfx_en(gfxB), .LED(ledB)
    );

    // Count one comparison and report it when it does not match
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one download byte; when the download flag is up the converted
    // word write is predicted and must strobe on the following cycle
    task automatic applyStimulus(input logic [21:0] addr, input logic [7:0] data);
        progTxn t;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = addr;
        bus.ioctl_data = data;
        if (bus.ioctl_download) begin
            t.addr = {1'b0, addr[21:1]};
            t.data = data;
            t.mask = addr[0] ? 2'b01 : 2'b10;
            expQ.push_back(t);
        end
        @(negedge clk_sys);
        checkOutput("prog_we_latency", bus.prog_we, bus.ioctl_download);
        bus.ioctl_wr = 1'b0;
    endtask

    // Count rising clock edges until rst (sel 0) or game_rst (sel 1) is low;
    // -1 means the budget ran out
    task automatic measureFall(input int sel, input int budget, output int cycles, output int pllHigh);
        bit done = 0;
        int i = 0;
        cycles  = -1;
        pllHigh = 0;
        while (!done && i < budget) begin
            @(posedge clk_sys);
            #1;
            i++;
            if (pll_rst) pllHigh++;
            if (((sel == 0) ? rst : game_rst) == 1'b0) begin
                cycles = i;
                done   = 1;
            end
        end
    endtask

    // Scoreboard: every prog_we pulse must match the oldest predicted write
    always @(negedge clk_sys) begin
        if (!RESET && bus.prog_we) begin
            if (expQ.size() == 0) begin
                checkOutput("prog_we_unexpected", bus.prog_we, 1'b0);
            end else begin
                progTxn t;
                t = expQ.pop_front();
                checkOutput("prog_addr", bus.prog_addr, t.addr);
                checkOutput("prog_data", bus.prog_data, t.data);
                checkOutput("prog_mask", bus.prog_mask, t.mask);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, pllHi, fallCyc, sawRst, expPll;
        RESET = 1'b1; pll_locked = 1'b1; status = 32'd0; buttons = 2'b00;
        joystick_0 = 16'd0; joystick_1 = 16'd0;
        bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = 22'd0; bus.ioctl_data = 8'd0;
        busB.ioctl_download = 1'b0; busB.ioctl_wr = 1'b0; busB.ioctl_addr = 22'd0; busB.ioctl_data = 8'd0;

        repeat (4) @(negedge clk_sys);
        checkOutput("reset_rst", {rst, rst_n, game_rst, game_rst_n}, 4'b1010);
        checkOutput("reset_pll_rst", pll_rst, 1'b0);
        checkOutput("reset_prog", {bus.prog_addr, bus.prog_data, bus.prog_mask, bus.prog_we, bus.prog_rd},
                    {22'd0, 8'd0, 2'b11, 1'b0, 1'b0});
        checkOutput("reset_joy", {game_joystick1, game_joystick2, game_coin, game_start, game_service},
                    {10'h3FF, 10'h3FF, 2'b11, 2'b11, 1'b1});
        checkOutput("reset_dips", {dip_test, enable_psg, enable_fm, dip_fxlevel, dip_flip, rotate, dip_pause, LED, gfx_en},
                    {1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF});

        // Release: 2 cycles to synchronise lock, then 255 cycles of hold
        RESET = 1'b0;
        measureFall(0, 600, cyc, pllHi);
        checkOutput("rst_release_cycles", cyc, 257);
        expPll = pllHi;
        measureFall(1, 600, cyc, pllHi);
        checkOutput("game_rst_release_cycles", cyc, 255);
        checkOutput("pll_rst_quiet", expPll + pllHi, 0);
        checkOutput("rst_n_after", {rst_n, game_rst_n}, 2'b11);

        // Joystick mapping
        @(negedge clk_sys);
        joystick_0 = 16'h0C10;
        @(negedge clk_sys);
        checkOutput("joy1_0C10", game_joystick1, 10'h3EF);
        checkOutput("coin_start_0C10", {game_coin, game_start, game_service}, {2'b10, 2'b10, 1'b1});
        joystick_0 = 16'h2040;
        joystick_1 = 16'h0801;
        @(negedge clk_sys);
        checkOutput("joy1_btn3_on", game_joystick1, 10'h3BF);
        checkOutput("joy1_btn3_forced", joy1B, 10'h3FF);
        checkOutput("joy2_map", game_joystick2, 10'h3FE);
        checkOutput("coin_service", {game_coin, game_service}, {2'b01, 1'b0});
        joystick_0 = 16'd0;
        joystick_1 = 16'd0;

        // DIP decode
        status = 32'h0000_0C80;
        @(negedge clk_sys);
        checkOutput("dip_C80", {enable_psg, enable_fm, dip_fxlevel, rotate, dip_flip, dip_test},
                    {1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1});
        status = 32'h0000_3140;
        @(negedge clk_sys);
        checkOutput("dip_3140", {enable_fm, dip_flip, rotate, dip_test, dip_fxlevel},
                    {1'b0, 1'b1, 1'b0, 1'b0, 2'b10});
        status = 32'd0;

        // Pause toggling
        @(negedge clk_sys);
        joystick_0[12] = 1'b1;
        @(negedge clk_sys);
        checkOutput("pause_on", {dip_pause, LED}, 2'b01);
        joystick_0[12] = 1'b0;
        @(negedge clk_sys);
        checkOutput("pause_hold", {dip_pause, LED}, 2'b01);
        joystick_1[12] = 1'b1;
        @(negedge clk_sys);
        checkOutput("pause_off", {dip_pause, LED}, 2'b10);
        joystick_1[12] = 1'b0;
        joystick_0[12] = 1'b1;
        @(negedge clk_sys);
        checkOutput("pause_again", dip_pause, 1'b0);
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        checkOutput("pause_cleared_by_dl", dip_pause, 1'b1);
        joystick_0[12] = 1'b0;

        // Download path
        checkOutput("dl_flags", {downloading, dwnld_busy, LED, game_rst}, 4'b1111);
        applyStimulus(22'h000005, 8'hAB);
        applyStimulus(22'h000010, 8'h5A);
        applyStimulus(22'h3FFFFF, 8'hC3);
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        measureFall(1, 600, cyc, pllHi);
        checkOutput("game_rst_after_dl", cyc, 256);
        applyStimulus(22'h000007, 8'h11);
        @(negedge clk_sys);
        checkOutput("ignored_write", bus.prog_we, 1'b0);
        checkOutput("dl_flag_low", {downloading, dwnld_busy}, 2'b00);

        // Status and button reset causes
        status = 32'h1;
        @(negedge clk_sys);
        checkOutput("status0_rst", {rst, rst_n}, 2'b10);
        status = 32'h0;
        measureFall(0, 600, cyc, pllHi);
        checkOutput("status0_release", cyc, 255);
        @(negedge clk_sys);
        buttons = 2'b10;
        @(negedge clk_sys);
        checkOutput("button_rst", rst, 1'b1);
        buttons = 2'b00;
        measureFall(0, 600, cyc, pllHi);
        checkOutput("button_release", cyc, 255);

        // One-cycle lock loss
        @(negedge clk_sys);
        pll_locked = 1'b0;
        @(negedge clk_sys);
        pll_locked = 1'b1;
        fallCyc = 0; sawRst = 0; pllHi = 0;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk_sys);
            #1;
            if (pll_rst) pllHi++;
            if (rst && sawRst == 0) sawRst = 1;
            if (sawRst == 1 && !rst && fallCyc == 0) fallCyc = i;
        end
        checkOutput("lockloss_rst_seen", sawRst, 1);
        checkOutput("lockloss_rst_release", fallCyc, 257);
`ifdef JTFRAME_LOCKRST_EN
        expPll = 256;
`else
        expPll = 0;
`endif
        checkOutput("lockloss_pll_rst_cycles", pllHi, expPll);

        checkOutput("prog_queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
